mbisr_repair_ctrl: RTL and testbench
====================================

Name: mbisr_repair_ctrl

Overview:
Built-in self-repair block on the receiving end of the MBIST failure-report interface (fail_valid/fail_addr).
- During a BIST run it logs unique failing addresses into a small table of spare word registers.
- After the run it sits between the system port and the main array, redirecting reads and writes for repaired addresses to the spares.
- Reports repair success, overflow and spares used.

Parameters:
ADDR_WIDTH, 8, memory address width (matches MBIST controller)
DATA_WIDTH, 8, memory word width
NUM_SPARES, 4, number of spare words (1..16)
CNT_WIDTH, 4, width of spares_used; must hold NUM_SPARES

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bist_start  in  1  pulse; same start given to MBIST controller
bist_done  in  1  pulse from MBIST controller at end of run
fail_valid  in  1  one-cycle failure report
fail_addr  in  ADDR_WIDTH  failing address, valid with fail_valid
sys_we  in  1  system write enable
sys_addr  in  ADDR_WIDTH  system address
sys_wdata  in  DATA_WIDTH  system write data
sys_rdata  out  DATA_WIDTH  system read data (combinational)
mm_we  out  1  main array write enable
mm_addr  out  ADDR_WIDTH  main array address
mm_wdata  out  DATA_WIDTH  main array write data
mm_rdata  in  DATA_WIDTH  main array asynchronous read data
repair_busy  out  1  high in COLLECT
repair_ok  out  1  high in REPAIRED
repair_fail  out  1  high in UNREPAIRABLE
spares_used  out  CNT_WIDTH  valid table entries
fail_count  out  8  total fail reports (see Optional Feature)

Behaviour:
- Reset: state IDLE; all entry valid bits, entry addresses and spare data cleared to 0; overflow flag 0; spares_used=0; repair_busy, repair_ok and repair_fail all 0; fail_count=0.
- States:
  - IDLE: bist_start -> COLLECT.
  - COLLECT: bist_done -> REPAIRED if overflow=0, else UNREPAIRABLE.
  - REPAIRED and UNREPAIRABLE: bist_start -> COLLECT.
- Entry to COLLECT (also from COLLECT on a repeated bist_start): clear every valid bit, spare data, overflow flag and spares_used in the same edge.
- Logging in COLLECT, on fail_valid:
  - fail_addr matches a valid entry: ignore (duplicate filter).
  - Otherwise, if a free entry exists: allocate the lowest free index, store the address, set valid, spares_used+1, spare data <= 0.
  - Otherwise: set overflow (sticky until next COLLECT entry).
  - fail_valid outside COLLECT is ignored.
- fail_valid and bist_done in the same cycle: the report is logged first; the final state reflects the updated overflow (combinational next-overflow drives the transition).
- Remap is active only in REPAIRED or UNREPAIRABLE (partial repair still applied).
  - hit = sys_addr equals the address of any valid entry; lowest index wins.
  - IDLE or COLLECT: pure bypass. mm_we=sys_we, mm_addr=sys_addr, mm_wdata=sys_wdata, sys_rdata=mm_rdata.
  - Remap active, no hit: bypass as above.
  - Remap active, hit: sys_rdata=spare[i] combinationally; mm_we forced 0; on sys_we, spare[i]<=sys_wdata at the clock edge. mm_addr/mm_wdata still pass through.
- Status outputs are decoded from registered state, so they change one cycle after the triggering input.
- bist_start takes priority over bist_done in the same cycle.
- Reset mid-run: returns to IDLE and discards the table.

Optional Feature:
Macro MBISR_FAIL_CNT_EN.
- Defined: fail_count is an 8-bit saturating counter (stops at 255) of every fail_valid seen in COLLECT, duplicates included; cleared on COLLECT entry and on rst.
- Undefined: fail_count tied to 0; no counter logic.

Decomposition:
- Package mbisr_pkg: state encoding localparams (IDLE=2'd0, COLLECT=2'd1, REPAIRED=2'd2, UNREPAIRABLE=2'd3) and the fail_count saturation constant.
- Sub-module mbisr_spare_cam (NUM_SPARES entries):
  - Holds valid/address/data registers.
  - Provides two match ports, one for fail_addr and one for sys_addr, each returning hit and lowest-index.
  - Provides free-slot find.
- The top level holds the FSM, overflow flag, counters and datapath mux.

Test Plan:
1. Reset, bist_start, fail at 0x10 and 0x20, bist_done -> repair_ok=1, spares_used=2; then sys write 0x10=0xA5 gives mm_we=0 and read 0x10=0xA5; read 0x11 returns mm_rdata.
2. fail_valid at 0x33 three times in COLLECT -> spares_used=1; fail_count=3 with MBISR_FAIL_CNT_EN defined, 0 when undefined.
3. Five unique fails (0x01..0x05) with NUM_SPARES=4, then bist_done -> repair_fail=1, spares_used=4, 0x01..0x04 remapped, 0x05 bypassed.
4. Fourth unique fail and bist_done in the same cycle with 3 spares used -> repair_ok=1, spares_used=4; repeat with 4 used -> repair_fail=1.
5. From REPAIRED, issue bist_start -> repair_busy=1, spares_used=0, sys access to previously repaired 0x10 reaches main array (mm_we follows sys_we).
6. rst asserted mid-COLLECT after 2 fails -> next cycle IDLE, all status outputs 0, spares_used=0, fail_valid then ignored.

Source files
------------

// File: rtl/mbisr_pkg.sv
// Shared types and constants for the MBISR repair controller.
package mbisr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_COLLECT      = 2'd1,
    ST_REPAIRED     = 2'd2,
    ST_UNREPAIRABLE = 2'd3
  } state_e;

  localparam int unsigned FAIL_CNT_W = 8;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = 8'd255;

endpackage

// File: rtl/mbisr_repair_ctrl_cam.sv
// Spare-word table: valid/address/data registers, two address match ports
// and a lowest-free-slot finder.
module mbisr_spare_cam #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SPARES = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  alloc_i,
  input  logic [ADDR_WIDTH-1:0] alloc_addr_i,
  input  logic                  wr_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] fail_addr_i,
  output logic                  fail_hit_o,
  output logic [IDX_W-1:0]      fail_idx_o,
  input  logic [ADDR_WIDTH-1:0] sys_addr_i,
  output logic                  sys_hit_o,
  output logic [IDX_W-1:0]      sys_idx_o,
  output logic [DATA_WIDTH-1:0] sys_data_o,
  output logic                  free_found_o,
  output logic [IDX_W-1:0]      free_idx_o
);

  logic                  valid_q [NUM_SPARES];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_SPARES];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SPARES];

  // Table update: clear on run start, allocate in COLLECT, spare writes when remapping
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_SPARES); i++) begin
      if (rst) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end else if (clear_i) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end else if (alloc_i && (free_idx_o == IDX_W'(i))) begin
        valid_q[i] <= 1'b1;
        addr_q[i]  <= alloc_addr_i;
        data_q[i]  <= '0;
      end else if (wr_i && (wr_idx_i == IDX_W'(i))) begin
        data_q[i]  <= wr_data_i;
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    fail_hit_o   = 1'b0;
    fail_idx_o   = '0;
    sys_hit_o    = 1'b0;
    sys_idx_o    = '0;
    sys_data_o   = '0;
    free_found_o = 1'b0;
    free_idx_o   = '0;
    for (int i = int'(NUM_SPARES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == fail_addr_i)) begin
        fail_hit_o = 1'b1;
        fail_idx_o = IDX_W'(i);
      end
      if (valid_q[i] && (addr_q[i] == sys_addr_i)) begin
        sys_hit_o  = 1'b1;
        sys_idx_o  = IDX_W'(i);
        sys_data_o = data_q[i];
      end
      if (!valid_q[i]) begin
        free_found_o = 1'b1;
        free_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mbisr_repair_ctrl.sv
// Built-in self-repair controller: logs MBIST failures into spare words and
// remaps system accesses. Optional fail counter enabled by MBISR_FAIL_CNT_EN.
module mbisr_repair_ctrl
  import mbisr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SPARES = 4,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bist_start,
  input  logic                  bist_done,
  input  logic                  fail_valid,
  input  logic [ADDR_WIDTH-1:0] fail_addr,
  input  logic                  sys_we,
  input  logic [ADDR_WIDTH-1:0] sys_addr,
  input  logic [DATA_WIDTH-1:0] sys_wdata,
  output logic [DATA_WIDTH-1:0] sys_rdata,
  output logic                  mm_we,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic [DATA_WIDTH-1:0] mm_wdata,
  input  logic [DATA_WIDTH-1:0] mm_rdata,
  output logic                  repair_busy,
  output logic                  repair_ok,
  output logic                  repair_fail,
  output logic [CNT_WIDTH-1:0]  spares_used,
  output logic [7:0]            fail_count
);

  localparam int unsigned IDX_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1;

  state_e               state_q;
  logic                 overflow_q;
  logic                 overflow_d;
  logic [CNT_WIDTH-1:0] spares_used_q;

  logic                  fail_hit;
  logic [IDX_W-1:0]      fail_idx;
  logic                  sys_hit;
  logic [IDX_W-1:0]      sys_idx;
  logic [DATA_WIDTH-1:0] spare_rdata;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;

  logic collecting;
  logic remap_en;
  logic log_fail;
  logic new_fail;
  logic alloc;
  logic spare_wr;
  logic remap_hit;

  assign collecting = (state_q == ST_COLLECT);
  assign remap_en   = (state_q == ST_REPAIRED) || (state_q == ST_UNREPAIRABLE);
  // A restart in the same cycle wipes the table, so the report is dropped
  assign log_fail   = collecting && fail_valid && !bist_start;
  assign new_fail   = log_fail && !fail_hit;
  assign alloc      = new_fail && free_found;
  assign overflow_d = overflow_q || (new_fail && !free_found);
  assign remap_hit  = remap_en && sys_hit;
  assign spare_wr   = remap_hit && sys_we;

  mbisr_spare_cam #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SPARES (NUM_SPARES),
    .IDX_W      (IDX_W)
  ) u_cam (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (bist_start),
    .alloc_i      (alloc),
    .alloc_addr_i (fail_addr),
    .wr_i         (spare_wr),
    .wr_idx_i     (sys_idx),
    .wr_data_i    (sys_wdata),
    .fail_addr_i  (fail_addr),
    .fail_hit_o   (fail_hit),
    .fail_idx_o   (fail_idx),
    .sys_addr_i   (sys_addr),
    .sys_hit_o    (sys_hit),
    .sys_idx_o    (sys_idx),
    .sys_data_o   (spare_rdata),
    .free_found_o (free_found),
    .free_idx_o   (free_idx)
  );

  // FSM, overflow flag and allocation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      overflow_q    <= 1'b0;
      spares_used_q <= '0;
    end else if (bist_start) begin
      state_q       <= ST_COLLECT;
      overflow_q    <= 1'b0;
      spares_used_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      if (alloc) begin
        spares_used_q <= spares_used_q + CNT_WIDTH'(1);
      end
      if (collecting && bist_done) begin
        state_q <= overflow_d ? ST_UNREPAIRABLE : ST_REPAIRED;
      end
    end
  end

`ifdef MBISR_FAIL_CNT_EN
  logic [FAIL_CNT_W-1:0] fail_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || bist_start) begin
      fail_cnt_q <= '0;
    end else if (log_fail && (fail_cnt_q != FAIL_CNT_MAX)) begin
      fail_cnt_q <= fail_cnt_q + FAIL_CNT_W'(1);
    end
  end

  assign fail_count = fail_cnt_q;
`else
  assign fail_count = '0;
`endif

  // Datapath: hits are served by the spare and never reach the main array
  assign mm_addr   = sys_addr;
  assign mm_wdata  = sys_wdata;
  assign mm_we     = remap_hit ? 1'b0 : sys_we;
  assign sys_rdata = remap_hit ? spare_rdata : mm_rdata;

  assign repair_busy = (state_q == ST_COLLECT);
  assign repair_ok   = (state_q == ST_REPAIRED);
  assign repair_fail = (state_q == ST_UNREPAIRABLE);
  assign spares_used = spares_used_q;

  logic unused_ok;
  assign unused_ok = ^{fail_idx, 1'b0};

endmodule

// File: tb/tb_mbisr_repair_ctrl.sv
// Table-driven self-checking bench for mbisr_repair_ctrl with an expected-result queue.
module tb_mbisr_repair_ctrl;

`ifdef MBISR_FAIL_CNT_EN
  localparam bit FCNT_EN = 1'b1;
`else
  localparam bit FCNT_EN = 1'b0;
`endif

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] SB = 3'b100;
  localparam logic [2:0] SO = 3'b010;
  localparam logic [2:0] SF = 3'b001;

  typedef struct {
    logic       rst;
    logic       bs;
    logic       bd;
    logic       fv;
    logic [7:0] fa;
    logic       we;
    logic [7:0] sa;
    logic [7:0] wd;
    logic [7:0] mrd;
    logic [7:0] xrd;
    logic       xwe;
    logic [2:0] xst;
    logic [3:0] xused;
    logic [7:0] xfc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       bist_start;
  logic       bist_done;
  logic       fail_valid;
  logic [7:0] fail_addr;
  logic       sys_we;
  logic [7:0] sys_addr;
  logic [7:0] sys_wdata;
  logic [7:0] sys_rdata;
  logic       mm_we;
  logic [7:0] mm_addr;
  logic [7:0] mm_wdata;
  logic [7:0] mm_rdata;
  logic       repair_busy;
  logic       repair_ok;
  logic       repair_fail;
  logic [3:0] spares_used;
  logic [7:0] fail_count;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  mbisr_repair_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bist_start  (bist_start),
    .bist_done   (bist_done),
    .fail_valid  (fail_valid),
    .fail_addr   (fail_addr),
    .sys_we      (sys_we),
    .sys_addr    (sys_addr),
    .sys_wdata   (sys_wdata),
    .sys_rdata   (sys_rdata),
    .mm_we       (mm_we),
    .mm_addr     (mm_addr),
    .mm_wdata    (mm_wdata),
    .mm_rdata    (mm_rdata),
    .repair_busy (repair_busy),
    .repair_ok   (repair_ok),
    .repair_fail (repair_fail),
    .spares_used (spares_used),
    .fail_count  (fail_count)
  );

  function automatic vec_t mk(logic r, logic bs, logic bd, logic fv, logic [7:0] fa,
                              logic we, logic [7:0] sa, logic [7:0] wd, logic [7:0] mrd,
                              logic [7:0] xrd, logic xwe, logic [2:0] xst,
                              logic [3:0] xused, logic [7:0] xfc);
    vec_t v;
    v.rst = r; v.bs = bs; v.bd = bd; v.fv = fv; v.fa = fa;
    v.we = we; v.sa = sa; v.wd = wd; v.mrd = mrd;
    v.xrd = xrd; v.xwe = xwe; v.xst = xst; v.xused = xused; v.xfc = xfc;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @vec%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Entered just after a rising edge: drive, compare mid-cycle, advance one cycle
  task automatic step(vec_t v, int idx);
    vec_t e;
    rst        = v.rst;
    bist_start = v.bs;
    bist_done  = v.bd;
    fail_valid = v.fv;
    fail_addr  = v.fa;
    sys_we     = v.we;
    sys_addr   = v.sa;
    sys_wdata  = v.wd;
    mm_rdata   = v.mrd;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("sys_rdata", idx, 32'(sys_rdata), 32'(e.xrd));
    chk("mm_we", idx, 32'(mm_we), 32'(e.xwe));
    chk("mm_addr", idx, 32'(mm_addr), 32'(e.sa));
    chk("mm_wdata", idx, 32'(mm_wdata), 32'(e.wd));
    chk("status", idx, 32'({repair_busy, repair_ok, repair_fail}), 32'(e.xst));
    chk("spares_used", idx, 32'(spares_used), 32'(e.xused));
    chk("fail_count", idx, 32'(fail_count), FCNT_EN ? 32'(e.xfc) : 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Basic repair of 0x10/0x20 and remapped access
    tbl.push_back(mk(0,0,0,0,'h00,0,'h10,'h00,'h3C, 'h3C,0,S0,0,0));
    tbl.push_back(mk(0,1,0,0,'h00,1,'h10,'h00,'h3C, 'h3C,1,S0,0,0));
    tbl.push_back(mk(0,0,0,1,'h10,0,'h00,'h00,'h55, 'h55,0,SB,0,0));
    tbl.push_back(mk(0,0,0,1,'h20,0,'h00,'h00,'h55, 'h55,0,SB,1,1));
    tbl.push_back(mk(0,0,1,0,'h00,0,'h00,'h00,'h55, 'h55,0,SB,2,2));
    tbl.push_back(mk(0,0,0,0,'h00,1,'h10,'hA5,'h3C, 'h00,0,SO,2,2));
    tbl.push_back(mk(0,0,0,0,'h00,0,'h10,'h00,'h3C, 'hA5,0,SO,2,2));
    tbl.push_back(mk(0,0,0,0,'h00,1,'h11,'h00,'h77, 'h77,1,SO,2,2));
    tbl.push_back(mk(0,0,0,0,'h00,0,'h20,'h00,'h77, 'h00,0,SO,2,2));
    // Restart from REPAIRED: table cleared, 0x10 goes to main array
    tbl.push_back(mk(0,1,0,0,'h00,0,'h10,'h00,'h11, 'hA5,0,SO,2,2));
    tbl.push_back(mk(0,0,0,0,'h00,1,'h10,'h00,'h11, 'h11,1,SB,0,0));
    // Duplicate filter on 0x33
    tbl.push_back(mk(0,0,0,1,'h33,0,'h00,'h00,'h00, 'h00,0,SB,0,0));
    tbl.push_back(mk(0,0,0,1,'h33,0,'h00,'h00,'h00, 'h00,0,SB,1,1));
    tbl.push_back(mk(0,0,0,1,'h33,0,'h00,'h00,'h00, 'h00,0,SB,1,2));
    tbl.push_back(mk(0,0,0,0,'h00,0,'h00,'h00,'h00, 'h00,0,SB,1,3));
    tbl.push_back(mk(0,0,1,0,'h00,0,'h00,'h00,'h00, 'h00,0,SB,1,3));
    // Five unique fails overflow four spares
    tbl.push_back(mk(0,1,0,0,'h00,0,'h00,'h00,'h00, 'h00,0,SO,1,3));
    tbl.push_back(mk(0,0,0,1,'h01,0,'h00,'h00,'h00, 'h00,0,SB,0,0));
    tbl.push_back(mk(0,0,0,1,'h02,0,'h00,'h00,'h00, 'h00,0,SB,1,1));
    tbl.push_back(mk(0,0,0,1,'h03,0,'h00,'h00,'h00, 'h00,0,SB,2,2));
    tbl.push_back(mk(0,0,0,1,'h04,0,'h00,'h00,'h00, 'h00,0,SB,3,3));
    tbl.push_back(mk(0,0,0,1,'h05,0,'h00,'h00,'h00, 'h00,0,SB,4,4));
    tbl.push_back(mk(0,0,1,0,'h00,0,'h00,'h00,'h00, 'h00,0,SB,4,5));
    tbl.push_back(mk(0,0,0,0,'h00,1,'h01,'h5A,'hEE, 'h00,0,SF,4,5));
    tbl.push_back(mk(0,0,0,0,'h00,0,'h04,'h00,'hEE, 'h00,0,SF,4,5));
    tbl.push_back(mk(0,0,0,0,'h00,1,'h05,'h00,'hEE, 'hEE,1,SF,4,5));
    tbl.push_back(mk(0,0,0,0,'h00,0,'h01,'h00,'hEE, 'h5A,0,SF,4,5));
    tbl.push_back(mk(0,0,0,1,'h77,0,'h00,'h00,'h12, 'h12,0,SF,4,5));
    tbl.push_back(mk(0,0,0,0,'h00,0,'h00,'h00,'h12, 'h12,0,SF,4,5));
    // Last fail and bist_done together: 3 used -> ok, 4 used -> fail
    tbl.push_back(mk(0,1,0,0,'h00,0,'h00,'h00,'h12, 'h12,0,SF,4,5));
    tbl.push_back(mk(0,0,0,1,'h40,0,'h00,'h00,'h00, 'h00,0,SB,0,0));
    tbl.push_back(mk(0,0,0,1,'h41,0,'h00,'h00,'h00, 'h00,0,SB,1,1));
    tbl.push_back(mk(0,0,0,1,'h42,0,'h00,'h00,'h00, 'h00,0,SB,2,2));
    tbl.push_back(mk(0,0,1,1,'h43,0,'h00,'h00,'h00, 'h00,0,SB,3,3));
    tbl.push_back(mk(0,1,0,0,'h00,0,'h43,'h00,'h66, 'h00,0,SO,4,4));
    tbl.push_back(mk(0,0,0,1,'h50,0,'h00,'h00,'h00, 'h00,0,SB,0,0));
    tbl.push_back(mk(0,0,0,1,'h51,0,'h00,'h00,'h00, 'h00,0,SB,1,1));
    tbl.push_back(mk(0,0,0,1,'h52,0,'h00,'h00,'h00, 'h00,0,SB,2,2));
    tbl.push_back(mk(0,0,0,1,'h53,0,'h00,'h00,'h00, 'h00,0,SB,3,3));
    tbl.push_back(mk(0,0,1,1,'h54,0,'h00,'h00,'h00, 'h00,0,SB,4,4));
    tbl.push_back(mk(0,0,0,0,'h00,1,'h54,'h00,'h66, 'h66,1,SF,4,5));
    // Reset in the middle of a run
    tbl.push_back(mk(0,1,0,0,'h00,0,'h00,'h00,'h00, 'h00,0,SF,4,5));
    tbl.push_back(mk(0,0,0,1,'h60,0,'h00,'h00,'h00, 'h00,0,SB,0,0));
    tbl.push_back(mk(0,0,0,1,'h61,0,'h00,'h00,'h00, 'h00,0,SB,1,1));
    tbl.push_back(mk(1,0,0,0,'h00,0,'h00,'h00,'h00, 'h00,0,SB,2,2));
    tbl.push_back(mk(0,0,0,1,'h62,0,'h00,'h00,'h00, 'h00,0,S0,0,0));
    tbl.push_back(mk(0,0,0,0,'h00,1,'h60,'h03,'h99, 'h99,1,S0,0,0));
    tbl.push_back(mk(0,0,0,0,'h00,0,'h00,'h00,'h00, 'h00,0,S0,0,0));

    rst = 1'b1; bist_start = 1'b0; bist_done = 1'b0; fail_valid = 1'b0;
    fail_addr = '0; sys_we = 1'b0; sys_addr = '0; sys_wdata = '0; mm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // bist_start wins over bist_done and restarts the table mid-run
    step(mk(0,1,0,0,'h00,0,'h00,'h00,'h00, 'h00,0,S0,0,0), 100);
    step(mk(0,0,0,1,'h70,0,'h00,'h00,'h00, 'h00,0,SB,0,0), 101);
    step(mk(0,1,1,0,'h00,0,'h00,'h00,'h00, 'h00,0,SB,1,1), 102);
    step(mk(0,0,0,1,'h71,0,'h00,'h00,'h00, 'h00,0,SB,0,0), 103);
    step(mk(0,0,1,0,'h00,0,'h00,'h00,'h00, 'h00,0,SB,1,1), 104);
    step(mk(0,0,0,0,'h00,0,'h71,'h00,'h44, 'h00,0,SO,1,1), 105);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
